vic_prio: RTL and testbench

//  Parametrised vectored interrupt controller on the MMIO peripheral bus. Successor to the fixed

---
 rtl/vic_pkg.sv | 23 ++
 rtl/vic_prio_arbiter.sv | 34 +++
 rtl/vic_prio.sv | 188 ++++++++++++++++++
 tb/tb_vic_prio.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vic_pkg.sv
// Shared definitions for the vectored interrupt controller.
// Register word offsets, STATUS field positions, vector defaults.
package vic_pkg;

  localparam logic [3:0] W_PEND = 4'd0;
  localparam logic [3:0] W_EDGE = 4'd1;
  localparam logic [3:0] W_MASK = 4'd2;
  localparam logic [3:0] W_STAT = 4'd3;
  localparam logic [3:0] W_PRIO = 4'd4;

  localparam int ST_DEPTH = 12;
  localparam int ST_LEVEL = 8;
  localparam int ST_ID    = 0;

  localparam logic [15:0] VEC_BASE_DEF   = 16'h0020;
  localparam logic [15:0] VEC_STRIDE_DEF = 16'h0020;

  typedef enum logic {
    S_IDLE,
    S_TAKE
  } take_st_t;

endpackage

// File: rtl/vic_prio_arbiter.sv
// Priority arbiter: picks the highest-level candidate, lowest id on ties.
// Ports: cand, prio (packed fields) in; valid, id, level out.
module vic_prio_arbiter
  import vic_pkg::*;
#(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 2
) (
  input  logic [N_SRC-1:0]        cand,
  input  logic [N_SRC*PRIO_W-1:0] prio,
  output logic                    valid,
  output logic [3:0]              id,
  output logic [PRIO_W:0]         level
);

  logic [PRIO_W:0] lv;

  // Scan downward with >= so equal levels resolve to the lower id.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    level = '0;
    lv    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      lv = {1'b0, prio[i*PRIO_W +: PRIO_W]} + (PRIO_W+1)'(1);
      if (cand[i] && lv >= level) begin
        valid = 1'b1;
        id    = 4'(i);
        level = lv;
      end
    end
  end

endmodule

// File: rtl/vic_prio.sv
// Vectored interrupt controller: PEND/EDGE/MASK/STATUS/PRIO registers,
// edge detect, level save stack and one-cycle take pulse with vector.
// Ports: i_clk, i_rst (sync, high), MMIO i_sel/i_we/i_re/i_addr/i_wdata,
// o_rdata/o_rdy, i_src, CPU i_in_irq/i_int_en/i_irq_ret,
// o_irq_take, o_irq_vector, o_cur_level.
// Macro VIC_NESTING_EN enables priority-based preemption.
module vic_prio
  import vic_pkg::*;
#(
  parameter int          N_SRC      = 8,
  parameter int          PRIO_W     = 2,
  parameter int          NEST_DEPTH = 4,
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sel,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [4:0]        i_addr,
  input  logic [15:0]       i_wdata,
  output logic [15:0]       o_rdata,
  output logic              o_rdy,
  input  logic [N_SRC-1:0]  i_src,
  input  logic              i_in_irq,
  input  logic              i_int_en,
  input  logic              i_irq_ret,
  output logic              o_irq_take,
  output logic [15:0]       o_irq_vector,
  output logic [PRIO_W:0]   o_cur_level
);

`ifdef VIC_NESTING_EN
  localparam bit NESTING = 1'b1;
`else
  localparam bit NESTING = 1'b0;
`endif
  localparam int SD = NESTING ? NEST_DEPTH : 1;
  localparam logic [3:0] SD4 = 4'(SD);
  localparam int LW  = PRIO_W + 1;
  localparam int FPW = 16 / PRIO_W;

  logic [N_SRC-1:0]        src_q, edge_r, mask_r, pend_q;
  logic [N_SRC-1:0]        pend, cand, clr, pend_d;
  logic [N_SRC*PRIO_W-1:0] prio_r;
  logic [LW-1:0]           cur_lvl;
  logic [LW-1:0]           stack [SD];
  logic [3:0]              depth;
  logic [15:0]             vec_q, vec_d;
  logic [3:0]              last_id;
  take_st_t                state_q, state_d;

  logic            win_vld;
  logic [3:0]      win_id;
  logic [LW-1:0]   win_lvl;
  logic [3:0]      wsel;
  logic            wr, gate, take_cond, pop;
  logic            unused_bits;

  assign wsel = i_addr[4:1];
  assign wr   = i_sel & i_we;
  assign unused_bits = &{1'b0, i_addr[0], i_wdata};

  // Edge sources show the latched bit, level sources follow the wire.
  assign pend = (pend_q & edge_r) | (i_src & ~edge_r);
  assign cand = pend & mask_r;

  vic_prio_arbiter #(
    .N_SRC  (N_SRC),
    .PRIO_W (PRIO_W)
  ) u_arb (
    .cand  (cand),
    .prio  (prio_r),
    .valid (win_vld),
    .id    (win_id),
    .level (win_lvl)
  );

  assign gate = NESTING ? (depth < SD4)
                        : (!i_in_irq && depth == 4'd0);

  assign take_cond = win_vld && i_int_en && !i_irq_ret
                  && state_q == S_IDLE
                  && win_lvl > cur_lvl && gate;

  assign pop   = i_irq_ret && depth != 4'd0;
  assign vec_d = VEC_BASE + 16'(win_id) * VEC_STRIDE;

  // OR-ing the new edge after the clear makes a fresh edge win.
  always_comb begin
    clr = '0;
    if (wr && wsel == W_PEND)
      clr = i_wdata[N_SRC-1:0];
    for (int i = 0; i < N_SRC; i++)
      if (take_cond && win_id == 4'(i))
        clr[i] = 1'b1;
    pend_d = ((pend_q & ~clr) | (edge_r & i_src & ~src_q)) & edge_r;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      src_q   <= '0;
      edge_r  <= '0;
      mask_r  <= '0;
      pend_q  <= '0;
      prio_r  <= '0;
      cur_lvl <= '0;
      depth   <= '0;
      vec_q   <= '0;
      last_id <= '0;
      for (int i = 0; i < SD; i++)
        stack[i] <= '0;
    end else begin
      src_q  <= i_src;
      pend_q <= pend_d;
      if (wr) begin
        case (wsel)
          W_EDGE:  edge_r <= i_wdata[N_SRC-1:0];
          W_MASK:  mask_r <= i_wdata[N_SRC-1:0];
          default: begin
            for (int k = 0; k < N_SRC; k++)
              if (int'(wsel) == int'(W_PRIO) + k / FPW)
                prio_r[k*PRIO_W +: PRIO_W] <=
                  i_wdata[PRIO_W*(k%FPW) +: PRIO_W];
          end
        endcase
      end
      if (take_cond) begin
        vec_q    <= vec_d;
        last_id  <= win_id;
        cur_lvl  <= win_lvl;
        depth    <= depth + 4'd1;
        stack[0] <= cur_lvl;
        for (int i = 1; i < SD; i++)
          stack[i] <= stack[i-1];
      end else if (pop) begin
        cur_lvl <= stack[0];
        depth   <= depth - 4'd1;
        for (int i = 0; i < SD - 1; i++)
          stack[i] <= stack[i+1];
        stack[SD-1] <= '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = take_cond ? S_TAKE : S_IDLE;
  end

  always_comb begin
    o_irq_take = (state_q == S_TAKE);
  end

  always_comb begin
    o_rdata = '0;
    if (i_sel && i_re) begin
      case (wsel)
        W_PEND: o_rdata[N_SRC-1:0] = pend;
        W_EDGE: o_rdata[N_SRC-1:0] = edge_r;
        W_MASK: o_rdata[N_SRC-1:0] = mask_r;
        W_STAT: begin
          o_rdata[ST_DEPTH +: 4] = depth;
          o_rdata[ST_LEVEL +: LW] = cur_lvl;
          o_rdata[ST_ID +: 4]    = last_id;
        end
        default: begin
          for (int k = 0; k < N_SRC; k++)
            if (int'(wsel) == int'(W_PRIO) + k / FPW)
              o_rdata[PRIO_W*(k%FPW) +: PRIO_W] =
                prio_r[k*PRIO_W +: PRIO_W];
        end
      endcase
    end
  end

  assign o_rdy        = 1'b1;
  assign o_irq_vector = vec_q;
  assign o_cur_level  = cur_lvl;

endmodule

// File: tb/tb_vic_prio.sv
// Directed bench for vic_prio.
// Hand-computed vectors, STATUS words and pending masks.
module tb_vic_prio;

  logic        clk = 1'b0;
  logic        i_rst, i_sel, i_we, i_re;
  logic [4:0]  i_addr;
  logic [15:0] i_wdata, o_rdata, o_irq_vector;
  logic        o_rdy, o_irq_take;
  logic [7:0]  i_src;
  logic        i_in_irq, i_int_en, i_irq_ret;
  logic [2:0]  o_cur_level;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] d;
  bit seen;

  always #5 clk = ~clk;

  vic_prio dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_sel        (i_sel),
    .i_we         (i_we),
    .i_re         (i_re),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_rdata      (o_rdata),
    .o_rdy        (o_rdy),
    .i_src        (i_src),
    .i_in_irq     (i_in_irq),
    .i_int_en     (i_int_en),
    .i_irq_ret    (i_irq_ret),
    .o_irq_take   (o_irq_take),
    .o_irq_vector (o_irq_vector),
    .o_cur_level  (o_cur_level)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] v);
    i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = v;
    @(negedge clk);
    i_sel = 1'b0; i_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [15:0] v);
    i_sel = 1'b1; i_re = 1'b1; i_addr = a;
    #1 v = o_rdata;
    i_sel = 1'b0; i_re = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    i_src = i_src | m;
    @(negedge clk);
    i_src = i_src & ~m;
  endtask

  task automatic wait_take(input int budget, output bit s);
    s = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_irq_take) begin
        s = 1'b1;
        break;
      end
    end
  endtask

  task automatic irq_ret();
    i_irq_ret = 1'b1; i_in_irq = 1'b0;
    @(negedge clk);
    i_irq_ret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_sel = 1'b0; i_we = 1'b0; i_re = 1'b0;
    i_addr = '0; i_wdata = '0; i_src = '0;
    i_in_irq = 1'b0; i_int_en = 1'b0; i_irq_ret = 1'b0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;

    chk("rst_take", o_irq_take, 0);
    chk("rst_vec", o_irq_vector, 0);
    chk("rst_lvl", o_cur_level, 0);
    chk("rst_rdy", o_rdy, 1);
    rd(5'h00, d); chk("rst_pend", d, 0);
    rd(5'h06, d); chk("rst_stat", d, 0);

    // single edge source 4
    i_int_en = 1'b1;
    wr(5'h02, 16'h0010);
    wr(5'h04, 16'h0010);
    wr(5'h08, 16'h0000);
    pulse(8'h10);
    wait_take(8, seen);
    chk("t1_take", seen, 1);
    chk("t1_vec", o_irq_vector, 16'h00A0);
    i_in_irq = 1'b1;
    @(negedge clk);
    chk("t1_pulse", o_irq_take, 0);
    rd(5'h00, d); chk("t1_pend", d, 16'h0000);
    rd(5'h06, d); chk("t1_stat", d, 16'h1104);
    irq_ret();
    rd(5'h06, d); chk("t1_ret", d, 16'h0004);

    // equal priority tie: src2 before src5
    wr(5'h02, 16'h0024);
    wr(5'h04, 16'h0024);
    wr(5'h08, 16'h0410);
    pulse(8'h24);
    wait_take(8, seen);
    chk("t2_take_a", seen, 1);
    chk("t2_vec_a", o_irq_vector, 16'h0060);
    i_in_irq = 1'b1;
    rd(5'h00, d); chk("t2_pend", d, 16'h0020);
    wait_take(6, seen);
    chk("t2_hold", seen, 0);
    irq_ret();
    wait_take(8, seen);
    chk("t2_take_b", seen, 1);
    chk("t2_vec_b", o_irq_vector, 16'h00C0);
    i_in_irq = 1'b1;
    @(negedge clk);
    irq_ret();

    // level source 3 gated by global enable
    wr(5'h02, 16'h0000);
    wr(5'h04, 16'h0008);
    wr(5'h08, 16'h0000);
    i_int_en = 1'b0;
    i_src[3] = 1'b1;
    wait_take(6, seen);
    chk("t3_gated", seen, 0);
    rd(5'h00, d); chk("t3_pend_a", d, 16'h0008);
    i_int_en = 1'b1;
    wait_take(4, seen);
    chk("t3_take", seen, 1);
    chk("t3_vec", o_irq_vector, 16'h0080);
    i_in_irq = 1'b1;
    rd(5'h00, d); chk("t3_pend_b", d, 16'h0008);
    i_src[3] = 1'b0;
    irq_ret();

    // src1 prio0 in service, src6 prio3 arrives
    wr(5'h02, 16'h0042);
    wr(5'h04, 16'h0042);
    wr(5'h08, 16'h3000);
    pulse(8'h02);
    wait_take(8, seen);
    chk("t4_take_a", seen, 1);
    chk("t4_vec_a", o_irq_vector, 16'h0040);
    i_in_irq = 1'b1;
    rd(5'h06, d); chk("t4_stat_a", d, 16'h1101);
    pulse(8'h40);
`ifdef VIC_NESTING_EN
    wait_take(6, seen);
    chk("t4_nest", seen, 1);
    chk("t4_vec_b", o_irq_vector, 16'h00E0);
    rd(5'h06, d); chk("t4_stat_b", d, 16'h2406);
    irq_ret();
    chk("t4_lvl", o_cur_level, 1);
    rd(5'h06, d); chk("t4_stat_c", d, 16'h1106);
    irq_ret();
    rd(5'h06, d); chk("t4_stat_d", d, 16'h0006);
`else
    wait_take(6, seen);
    chk("t5_blocked", seen, 0);
    chk("t5_vec_hold", o_irq_vector, 16'h0040);
    irq_ret();
    wait_take(6, seen);
    chk("t5_take", seen, 1);
    chk("t5_vec_b", o_irq_vector, 16'h00E0);
    rd(5'h06, d); chk("t5_stat", d, 16'h1406);
    irq_ret();
`endif

    // W1C on masked pending edge, then reset mid-service
    wr(5'h02, 16'h0010);
    wr(5'h04, 16'h0000);
    wr(5'h08, 16'h0000);
    pulse(8'h10);
    @(negedge clk);
    rd(5'h00, d); chk("t6_pend_a", d, 16'h0010);
    wr(5'h00, 16'h0010);
    rd(5'h00, d); chk("t6_w1c", d, 16'h0000);
    wr(5'h04, 16'h0010);
    wait_take(6, seen);
    chk("t6_none", seen, 0);
    pulse(8'h10);
    wait_take(8, seen);
    chk("t6_take", seen, 1);
    i_in_irq = 1'b1;
    chk("t6_lvl_a", o_cur_level, 1);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0; i_in_irq = 1'b0;
    chk("t6_lvl_b", o_cur_level, 0);
    chk("t6_vec", o_irq_vector, 0);
    rd(5'h06, d); chk("t6_stat", d, 16'h0000);
    rd(5'h04, d); chk("t6_mask", d, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
